// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the SDRAM command bus to one of the init, auto-refresh,
// write or read engines. Muxes the granted engine's cmd/addr/bank onto the pins,
// registers write data onto DQ and opens the DQ output enable for one burst
// after each WR command.
//
// Optional feature: define ARB_RR_EN to alternate write and read when both are
// pending in ARBIT. When it is undefined, write always beats read. Refresh
// always wins either way.
//
// Grant handshake: an engine holds its request (level) until it sees its grant.
// The grant is a registered level that stays high for the whole tenure. The
// engine ends the tenure with a one-cycle end pulse, or, for the write engine,
// by dropping write_req and raising it again after a refresh preemption.
// state_dbg (one-hot FSM state) and byte_end_seen are debug outputs.
module sdram_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 4,
   parameter int WD_CYCLES = 1023
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              write_req,
   input  logic              write_end,
   input  logic              byte_end,
   input  logic [3:0]        write_cmd,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [1:0]        bank_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read_req,
   input  logic              read_end,
   input  logic [3:0]        read_cmd,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [1:0]        read_bank,
   output logic              aref_en,
   output logic              write_en,
   output logic              read_en,
   output logic              refresh_req,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [1:0]        sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DATA_W-1:0] sdram_dq_out,
   output logic              sdram_dq_oe,
   output logic              arb_err,
   output logic [4:0]        state_dbg,
   output logic              byte_end_seen
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_WR  = 4'b0100;

   localparam int WD_W = $clog2(WD_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

   localparam int BL_W = $clog2(BURST_LEN + 1);
   localparam logic [BL_W-1:0] BL_RELOAD = BL_W'(BURST_LEN - 1);

   typedef enum logic [4:0] {
      ST_INIT  = 5'b00001,
      ST_ARBIT = 5'b00010,
      ST_AREF  = 5'b00100,
      ST_WRITE = 5'b01000,
      ST_READ  = 5'b10000
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [WD_W-1:0]   wd_cnt;
   logic              tenure;
   logic              wd_fire;
   logic              req_low_seen;
   logic [BL_W-1:0]   oe_cnt;
   logic              wr_now;
   logic [3:0]        cmd;

`ifdef ARB_RR_EN
   // 1 = write was the last of write/read to be granted; resets to read
   logic              last_write;
`endif

   // A tenure is any state owned by a requesting engine; only these are watched
   assign tenure  = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
   assign wd_fire = tenure && (wd_cnt == WD_LAST);

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= ST_INIT;
      else         state <= next_state;
   end

   // Next-state: end pulses are handled before new requests; the watchdog overrides all
   always_comb begin
      next_state = state;
      case (state)
         ST_INIT: begin
            if (init_end) next_state = ST_ARBIT;
         end
         ST_ARBIT: begin
            if (aref_req) begin
               next_state = ST_AREF;
            end else if (write_req && read_req) begin
`ifdef ARB_RR_EN
               next_state = last_write ? ST_READ : ST_WRITE;
`else
               next_state = ST_WRITE;
`endif
            end else if (write_req) begin
               next_state = ST_WRITE;
            end else if (read_req) begin
               next_state = ST_READ;
            end
         end
         ST_AREF: begin
            if (aref_end) next_state = ST_ARBIT;
         end
         ST_WRITE: begin
            // A request edge after a low sample means the engine was preempted and
            // wants to rejoin arbitration behind the refresh.
            if (write_end || (req_low_seen && write_req)) next_state = ST_ARBIT;
         end
         ST_READ: begin
            if (read_end) next_state = ST_ARBIT;
         end
         default: next_state = ST_INIT;
      endcase
      if (wd_fire) next_state = ST_ARBIT;
   end

   // Grants are registered copies of the state being entered
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         aref_en  <= 1'b0;
         write_en <= 1'b0;
         read_en  <= 1'b0;
      end else begin
         aref_en  <= (next_state == ST_AREF);
         write_en <= (next_state == ST_WRITE);
         read_en  <= (next_state == ST_READ);
      end
   end

`ifdef ARB_RR_EN
   // Remember which of write/read won last so the other wins the next tie
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         last_write <= 1'b0;
      end else if (state == ST_ARBIT) begin
         if (next_state == ST_WRITE)     last_write <= 1'b1;
         else if (next_state == ST_READ) last_write <= 1'b0;
      end
   end
`endif

   // Tenure watchdog: zero on the first cycle of every state, counts inside tenures
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                   wd_cnt <= '0;
      else if (next_state != state)  wd_cnt <= '0;
      else if (tenure)               wd_cnt <= wd_cnt + 1'b1;
      else                           wd_cnt <= '0;
   end

   // Sticky error: only reset clears a watchdog expiry
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)      arb_err <= 1'b0;
      else if (wd_fire) arb_err <= 1'b1;
   end

   // Per-tenure write flags: request-low history and burst-close debug marker
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         req_low_seen  <= 1'b0;
         byte_end_seen <= 1'b0;
      end else if (state != ST_WRITE) begin
         req_low_seen  <= 1'b0;
         byte_end_seen <= 1'b0;
      end else begin
         if (!write_req) req_low_seen  <= 1'b1;
         if (byte_end)   byte_end_seen <= 1'b1;
      end
   end

   // Pin mux: combinational on the registered state, so commands pass with no added latency
   always_comb begin
      cmd        = CMD_NOP;
      sdram_addr = '0;
      sdram_ba   = 2'b00;
      case (state)
         ST_INIT: begin
            cmd        = init_cmd;
            sdram_addr = init_addr;
         end
         ST_AREF: begin
            cmd        = aref_cmd;
            sdram_addr = aref_addr;
         end
         ST_WRITE: begin
            cmd        = write_cmd;
            sdram_addr = write_addr;
            sdram_ba   = bank_addr;
         end
         ST_READ: begin
            cmd        = read_cmd;
            sdram_addr = read_addr;
            sdram_ba   = read_bank;
         end
         default: begin
            cmd        = CMD_NOP;
            sdram_addr = '0;
            sdram_ba   = 2'b00;
         end
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

   // Write data arrives combinationally one cycle ahead; one register lines it up with WR
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) sdram_dq_out <= '0;
      else         sdram_dq_out <= write_data;
   end

   // DQ enable: the WR cycle itself plus BURST_LEN-1 more; a new WR reloads the count
   assign wr_now = (state == ST_WRITE) && (write_cmd == CMD_WR);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)            oe_cnt <= '0;
      else if (wr_now)        oe_cnt <= BL_RELOAD;
      else if (oe_cnt != '0)  oe_cnt <= oe_cnt - 1'b1;
   end

   assign sdram_dq_oe = wr_now || (oe_cnt != '0);

   assign refresh_req = aref_req;
   assign sdram_cke   = 1'b1;
   assign state_dbg   = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a write-engine driver pushes expected DQ words into a
// queue as it presents write data; a negedge monitor pops one word for every
// cycle the DQ enable is open and compares it with sdram_dq_out.
module tb_sdram_arbiter;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 16;
   localparam int BURST_LEN = 4;
   localparam int WD_CYCLES = 15;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] ACT  = 4'b0011;
   localparam logic [3:0] WR   = 4'b0100;
   localparam logic [3:0] RD   = 4'b0101;
   localparam logic [3:0] PRE  = 4'b0010;
   localparam logic [3:0] AREF = 4'b0001;

   localparam logic [4:0] S_INIT  = 5'b00001;
   localparam logic [4:0] S_ARBIT = 5'b00010;
   localparam logic [4:0] S_AREF  = 5'b00100;
   localparam logic [4:0] S_WRITE = 5'b01000;
   localparam logic [4:0] S_READ  = 5'b10000;

   logic              clk;
   logic              sys_rst;
   logic              init_end;
   logic [3:0]        init_cmd;
   logic [ADDR_W-1:0] init_addr;
   logic              aref_req, aref_end;
   logic [3:0]        aref_cmd;
   logic [ADDR_W-1:0] aref_addr;
   logic              write_req, write_end, byte_end;
   logic [3:0]        write_cmd;
   logic [ADDR_W-1:0] write_addr;
   logic [1:0]        bank_addr;
   logic [DATA_W-1:0] write_data;
   logic              read_req, read_end;
   logic [3:0]        read_cmd;
   logic [ADDR_W-1:0] read_addr;
   logic [1:0]        read_bank;
   logic              aref_en, write_en, read_en, refresh_req, sdram_cke;
   logic              sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]        sdram_ba;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_dq_out;
   logic              sdram_dq_oe, arb_err;
   logic [4:0]        state_dbg;
   logic              byte_end_seen;
   logic [3:0]        pin_cmd;

   int vectors = 0;
   int miscompares = 0;
   logic [DATA_W-1:0] exp_q[$];

   assign pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

   sdram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .WD_CYCLES(WD_CYCLES)
   ) dut (
      .sys_clk(clk), .sys_rst(sys_rst),
      .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
      .write_req(write_req), .write_end(write_end), .byte_end(byte_end),
      .write_cmd(write_cmd), .write_addr(write_addr), .bank_addr(bank_addr),
      .write_data(write_data),
      .read_req(read_req), .read_end(read_end), .read_cmd(read_cmd),
      .read_addr(read_addr), .read_bank(read_bank),
      .aref_en(aref_en), .write_en(write_en), .read_en(read_en),
      .refresh_req(refresh_req), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
      .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
      .arb_err(arb_err), .state_dbg(state_dbg), .byte_end_seen(byte_end_seen)
   );

   // Clock and reset default
   initial begin
      clk = 1'b0;
      sys_rst = 1'b1;
   end
   always #5 clk = ~clk;

   // Scoreboard: every open DQ-enable cycle must deliver the next queued word
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_w;
      if (sdram_dq_oe) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL dq_window: dq_oe open with nothing expected, dq_out=%h", sdram_dq_out);
         end else begin
            exp_w = exp_q.pop_front();
            if (sdram_dq_out !== exp_w) begin
               miscompares++;
               $display("FAIL dq_out: got %h expected %h", sdram_dq_out, exp_w);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      init_end = 0; init_cmd = NOP; init_addr = '0;
      aref_req = 0; aref_end = 0; aref_cmd = NOP; aref_addr = '0;
      write_req = 0; write_end = 0; byte_end = 0; write_cmd = NOP;
      write_addr = '0; bank_addr = 2'd0; write_data = '0;
      read_req = 0; read_end = 0; read_cmd = NOP; read_addr = '0; read_bank = 2'd0;
   endtask

   task automatic do_reset_init();
      idle_inputs();
      exp_q.delete();
      sys_rst = 1;
      next_cycle();
      next_cycle();
      sys_rst = 0;
      next_cycle();
      init_end = 1;
      next_cycle();
      init_end = 0;
   endtask

   // Write engine tenure: called in the first granted cycle. ACT, data lead, WR, 3 data, end.
   task automatic write_body(input logic [DATA_W-1:0] base);
      write_req = 0; write_cmd = ACT; write_addr = 12'h055; bank_addr = 2'd1;
      sample();
      vectors++;
      if ({state_dbg, write_en} !== {S_WRITE, 1'b1}) begin
         miscompares++;
         $display("FAIL wr_grant: state/write_en got %b/%b expected %b/1", state_dbg, write_en, S_WRITE);
      end
      vectors++;
      if ({pin_cmd, sdram_addr, sdram_ba} !== {ACT, 12'h055, 2'd1}) begin
         miscompares++;
         $display("FAIL wr_act_pins: got %h/%h/%h expected %h/055/1", pin_cmd, sdram_addr, sdram_ba, ACT);
      end
      next_cycle();
      write_cmd = NOP; write_data = base; exp_q.push_back(base);
      next_cycle();
      write_cmd = WR; write_addr = 12'h008; write_data = base + 16'd2; exp_q.push_back(base + 16'd2);
      sample();
      vectors++;
      if ({pin_cmd, sdram_dq_oe} !== {WR, 1'b1}) begin
         miscompares++;
         $display("FAIL wr_cmd_oe: cmd/oe got %h/%b expected %h/1", pin_cmd, sdram_dq_oe, WR);
      end
      for (int k = 2; k < 4; k++) begin
         next_cycle();
         write_cmd = NOP;
         write_data = base + 16'(2 * k);
         exp_q.push_back(base + 16'(2 * k));
      end
      next_cycle();
      write_data = '0; write_end = 1;
      sample();
      vectors++;
      if (sdram_dq_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL oe_last: got %b expected 1", sdram_dq_oe);
      end
      next_cycle();
      write_end = 0;
      sample();
      vectors++;
      if ({state_dbg, write_en, sdram_dq_oe} !== {S_ARBIT, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL wr_exit: state/write_en/oe got %b/%b/%b expected %b/0/0",
                  state_dbg, write_en, sdram_dq_oe, S_ARBIT);
      end
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL wr_drain: %0d words left, expected 0", exp_q.size());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      sys_rst = 1;
      next_cycle();
      next_cycle();
      sample();
      vectors++;
      if ({state_dbg, aref_en, write_en, read_en, pin_cmd, sdram_ba, sdram_dq_oe, arb_err, sdram_cke}
          !== {S_INIT, 3'b000, NOP, 2'b00, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: st=%b grants=%b%b%b cmd=%h ba=%h oe=%b err=%b cke=%b",
                  state_dbg, aref_en, write_en, read_en, pin_cmd, sdram_ba, sdram_dq_oe, arb_err, sdram_cke);
      end
      vectors++;
      if ({sdram_addr, sdram_dq_out} !== {12'h000, 16'h0000}) begin
         miscompares++;
         $display("FAIL reset_data: addr/dq got %h/%h expected 000/0000", sdram_addr, sdram_dq_out);
      end
      next_cycle();
      sys_rst = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin init_cmd = PRE; init_addr = 12'h400; end
         if (i == 4) begin init_cmd = NOP; init_addr = 12'h123; end
         sample();
         vectors++;
         if (state_dbg !== S_INIT) begin
            miscompares++;
            $display("FAIL init_hold: cycle %0d state got %b expected %b", i, state_dbg, S_INIT);
         end
         if (i == 3) begin
            vectors++;
            if ({pin_cmd, sdram_addr, sdram_ba} !== {PRE, 12'h400, 2'd0}) begin
               miscompares++;
               $display("FAIL init_pins: got %h/%h/%h expected %h/400/0", pin_cmd, sdram_addr, sdram_ba, PRE);
            end
         end
         next_cycle();
      end
      init_end = 1;
      next_cycle();
      init_end = 0;
      sample();
      vectors++;
      if ({state_dbg, pin_cmd, sdram_addr} !== {S_ARBIT, NOP, 12'h000}) begin
         miscompares++;
         $display("FAIL arbit_entry: state/cmd/addr got %b/%h/%h expected %b/%h/000",
                  state_dbg, pin_cmd, sdram_addr, S_ARBIT, NOP);
      end
   endtask

   task automatic test_write();
      next_cycle();
      write_req = 1;
      sample();
      vectors++;
      if (write_en !== 1'b0) begin
         miscompares++;
         $display("FAIL grant_latency: write_en got %b expected 0 in request cycle", write_en);
      end
      next_cycle();
      write_body(16'd3);
   endtask

   task automatic test_preempt();
      next_cycle();
      write_req = 1;
      next_cycle();
      write_req = 0; write_cmd = ACT; aref_req = 1;
      sample();
      vectors++;
      if ({write_en, refresh_req} !== 2'b11) begin
         miscompares++;
         $display("FAIL refresh_fwd: write_en/refresh_req got %b%b expected 11", write_en, refresh_req);
      end
      next_cycle();
      write_cmd = PRE; byte_end = 1;
      next_cycle();
      byte_end = 0; write_cmd = NOP; write_req = 1;
      sample();
      vectors++;
      if ({state_dbg, write_en, byte_end_seen} !== {S_WRITE, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL byte_end_stay: state/en/flag got %b/%b/%b expected %b/1/1",
                  state_dbg, write_en, byte_end_seen, S_WRITE);
      end
      next_cycle();
      sample();
      vectors++;
      if ({state_dbg, write_en} !== {S_ARBIT, 1'b0}) begin
         miscompares++;
         $display("FAIL preempt_exit: state/en got %b/%b expected %b/0", state_dbg, write_en, S_ARBIT);
      end
      next_cycle();
      aref_cmd = AREF; aref_addr = 12'h400;
      sample();
      vectors++;
      if ({state_dbg, aref_en, pin_cmd, sdram_addr, sdram_ba} !== {S_AREF, 1'b1, AREF, 12'h400, 2'd0}) begin
         miscompares++;
         $display("FAIL aref_grant: st=%b en=%b cmd=%h addr=%h ba=%h", state_dbg, aref_en, pin_cmd, sdram_addr, sdram_ba);
      end
      next_cycle();
      aref_req = 0; aref_cmd = NOP;
      next_cycle();
      next_cycle();
      aref_end = 1;
      sample();
      vectors++;
      if (aref_en !== 1'b1) begin
         miscompares++;
         $display("FAIL aref_hold: aref_en got %b expected 1", aref_en);
      end
      next_cycle();
      aref_end = 0;
      sample();
      vectors++;
      if ({state_dbg, aref_en} !== {S_ARBIT, 1'b0}) begin
         miscompares++;
         $display("FAIL aref_exit: state/en got %b/%b expected %b/0", state_dbg, aref_en, S_ARBIT);
      end
      next_cycle();
      write_body(16'h0100);
   endtask

   task automatic test_arbitration();
      logic exp_read;
      do_reset_init();
      write_addr = 12'h033; bank_addr = 2'd3;
      read_cmd = RD; read_addr = 12'h0AA; read_bank = 2'd2;
      write_req = 1; read_req = 1;
      for (int k = 0; k < 3; k++) begin
`ifdef ARB_RR_EN
         exp_read = (k == 1);
`else
         exp_read = 1'b0;
`endif
         next_cycle();
         sample();
         vectors++;
         if ({write_en, read_en} !== {!exp_read, exp_read}) begin
            miscompares++;
            $display("FAIL arb_order: grant %0d write/read got %b%b expected %b%b",
                     k, write_en, read_en, !exp_read, exp_read);
         end
         vectors++;
         if ({pin_cmd, sdram_addr, sdram_ba} !== (exp_read ? {RD, 12'h0AA, 2'd2} : {NOP, 12'h033, 2'd3})) begin
            miscompares++;
            $display("FAIL arb_pins: grant %0d got %h/%h/%h", k, pin_cmd, sdram_addr, sdram_ba);
         end
         next_cycle();
         if (exp_read) read_end = 1;
         else          write_end = 1;
         next_cycle();
         read_end = 0; write_end = 0;
         sample();
         vectors++;
         if ({state_dbg, write_en, read_en} !== {S_ARBIT, 2'b00}) begin
            miscompares++;
            $display("FAIL end_first: state/grants got %b/%b%b expected %b/00", state_dbg, write_en, read_en, S_ARBIT);
         end
      end
      write_req = 0; read_req = 0;
      next_cycle();
   endtask

   task automatic test_watchdog();
      write_req = 1;
      next_cycle();
      write_req = 0;
      for (int i = 1; i <= WD_CYCLES; i++) begin
         sample();
         vectors++;
         if ({state_dbg, arb_err} !== {S_WRITE, 1'b0}) begin
            miscompares++;
            $display("FAIL wd_hold: cycle %0d state/err got %b/%b expected %b/0", i, state_dbg, arb_err, S_WRITE);
         end
         next_cycle();
      end
      sample();
      vectors++;
      if ({state_dbg, write_en, arb_err} !== {S_ARBIT, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL wd_fire: state/en/err got %b/%b/%b expected %b/0/1", state_dbg, write_en, arb_err, S_ARBIT);
      end
      next_cycle();
      read_req = 1;
      next_cycle();
      read_req = 0; read_end = 1;
      next_cycle();
      read_end = 0;
      sample();
      vectors++;
      if ({state_dbg, arb_err} !== {S_ARBIT, 1'b1}) begin
         miscompares++;
         $display("FAIL err_sticky: state/err got %b/%b expected %b/1", state_dbg, arb_err, S_ARBIT);
      end
   endtask

   task automatic test_reset_mid_burst();
      next_cycle();
      write_req = 1;
      next_cycle();
      write_req = 0; write_cmd = ACT;
      next_cycle();
      write_cmd = NOP; write_data = 16'hA5A5; exp_q.push_back(16'hA5A5);
      next_cycle();
      write_cmd = WR; write_data = 16'h5A5A; exp_q.push_back(16'h5A5A);
      sample();
      vectors++;
      if (sdram_dq_oe !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_oe: got %b expected 1", sdram_dq_oe);
      end
      next_cycle();
      sys_rst = 1;
      sample();
      vectors++;
      if ({state_dbg, write_en, sdram_dq_oe, pin_cmd, arb_err} !== {S_INIT, 1'b0, 1'b0, NOP, 1'b0}) begin
         miscompares++;
         $display("FAIL mid_reset: st=%b en=%b oe=%b cmd=%h err=%b", state_dbg, write_en, sdram_dq_oe, pin_cmd, arb_err);
      end
      vectors++;
      if (sdram_dq_out !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_reset_dq: got %h expected 0000", sdram_dq_out);
      end
      exp_q.delete();
      idle_inputs();
      next_cycle();
      sys_rst = 0;
      next_cycle();
   endtask

   // Sequencer and final report
   initial begin
      test_reset();
      test_write();
      test_preempt();
      test_arbitration();
      test_watchdog();
      test_reset_mid_burst();
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL final_drain: %0d words left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
